// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-source round-robin packet arbiter.
//   ST_IDLE / ST_BUSY : arbiter state encoding (1 bit)
//   SRC0 / SRC1       : source index values carried on the mux select
//   rr_pick()         : round-robin choice among the currently valid sources
package mux_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // On a tie the source that was not served last wins; a lone requester always wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last_served);
        logic pick;
        if (v0 && v1) begin
            pick = ~last_served;
        end else if (v1) begin
            pick = SRC1;
        end else begin
            pick = SRC0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_2x1_bus.sv
// Vector 2:1 multiplexer.
//   s  : select (0 -> x1, 1 -> x2)
//   x1 : input vector chosen when s=0
//   x2 : input vector chosen when s=1
//   f  : selected vector
module mux_2x1_bus #(
    parameter int unsigned W = 8
) (
    input  logic         s,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic [W-1:0] f
);

    assign f = s ? x2 : x1;

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter sharing one master stream port between two valid/ready/last sources.
// A grant is held for a whole packet and released after the last beat is accepted, leaving
// one idle cycle before the next grant.
//   clk, rst          : clock, asynchronous active-high reset
//   s0_* / s1_*       : source streams (data, valid, last in; ready out)
//   m_data/valid/last : muxed master stream out, m_ready in
//   sel               : registered mux select (0 = s0, 1 = s1)
//   busy              : high while a grant is locked
module mux_2x1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s0_data,
    input  logic         s0_valid,
    input  logic         s0_last,
    output logic         s0_ready,
    input  logic [W-1:0] s1_data,
    input  logic         s1_valid,
    input  logic         s1_last,
    output logic         s1_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    output logic         m_last,
    input  logic         m_ready,
    output logic         sel,
    output logic         busy
);

    logic state_q, state_d;
    logic sel_q, sel_d;
    logic last_served_q, last_served_d;

    logic [W+1:0] bus_x1;
    logic [W+1:0] bus_x2;
    logic [W+1:0] bus_f;
    logic         mux_valid;
    logic         pkt_done;

    // Data, last and valid travel through one mux so they are always steered together.
    assign bus_x1 = {s0_data, s0_last, s0_valid};
    assign bus_x2 = {s1_data, s1_last, s1_valid};

    mux_2x1_bus #(
        .W (W + 2)
    ) u_bus (
        .s  (sel_q),
        .x1 (bus_x1),
        .x2 (bus_x2),
        .f  (bus_f)
    );

    assign m_data    = bus_f[W+1:2];
    assign m_last    = bus_f[1];
    assign mux_valid = bus_f[0];

    assign busy     = (state_q == ST_BUSY);
    assign sel      = sel_q;
    // Outputs decode straight from state so an asynchronous reset drops them immediately.
    assign m_valid  = busy & mux_valid;
    assign s0_ready = busy & (sel_q == SRC0) & m_ready;
    assign s1_ready = busy & (sel_q == SRC1) & m_ready;
    assign pkt_done = m_valid & m_ready & m_last;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_served_d = last_served_q;
        case (state_q)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    state_d = ST_BUSY;
                    sel_d   = rr_pick(s0_valid, s1_valid, last_served_q);
                end
            end
            ST_BUSY: begin
                if (pkt_done) begin
                    state_d       = ST_IDLE;
                    last_served_d = sel_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= SRC0;
            last_served_q <= SRC1;  // makes s0 win the first tie
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_served_q <= last_served_d;
        end
    end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
module tb_mux_2x1_arbiter;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] s0_data, s1_data, m_data;
    logic         s0_valid, s0_last, s0_ready;
    logic         s1_valid, s1_last, s1_ready;
    logic         m_valid, m_last, m_ready;
    logic         sel, busy;

    mux_2x1_arbiter #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_data  (s0_data),
        .s0_valid (s0_valid),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_data  (s1_data),
        .s1_valid (s1_valid),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .sel      (sel),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         s0_valid, s0_last;
        logic [W-1:0] s0_data;
        logic         s1_valid, s1_last;
        logic [W-1:0] s1_data;
        logic         m_ready;
        logic         e_busy, e_sel, e_m_valid, e_s0_ready, e_s1_ready;
        logic [W-1:0] e_m_data;
        logic         e_m_last;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic         sel;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    accepts = 0;
    exp_t  exp_q[$];
    beat_t s0q[$];
    beat_t s1q[$];
    vec_t  vecs[$];

    logic smp_busy, smp_sel, smp_mvalid, smp_s0r, smp_s1r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s0v, input logic s0l, input logic [W-1:0] s0d,
                                input logic s1v, input logic s1l, input logic [W-1:0] s1d,
                                input logic mr, input logic eb, input logic es,
                                input logic emv, input logic e0r, input logic e1r,
                                input logic [W-1:0] ed, input logic el);
        vec_t v;
        v.s0_valid = s0v; v.s0_last = s0l; v.s0_data = s0d;
        v.s1_valid = s1v; v.s1_last = s1l; v.s1_data = s1d;
        v.m_ready = mr;
        v.e_busy = eb; v.e_sel = es; v.e_m_valid = emv;
        v.e_s0_ready = e0r; v.e_s1_ready = e1r;
        v.e_m_data = ed; v.e_m_last = el;
        return v;
    endfunction

    function automatic exp_t mke(input logic [W-1:0] d, input logic l, input logic s);
        exp_t e;
        e.data = d; e.last = l; e.sel = s;
        return e;
    endfunction

    function automatic beat_t mkb(input logic [W-1:0] d, input logic l);
        beat_t b;
        b.data = d; b.last = l;
        return b;
    endfunction

    // Monitor: samples 1 ns before each rising edge; scoreboard plus invariants.
    logic prev_rst = 1'b1;
    logic prev_busy = 1'b0;
    logic prev_sel = 1'b0;
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            chk("inv_both_ready", {31'd0, s0_ready & s1_ready}, 32'd0);
            chk("inv_idle_ready", {31'd0, ~busy & (s0_ready | s1_ready)}, 32'd0);
            if (!prev_rst) begin
                chk("inv_sel_change",
                    {31'd0, (sel == prev_sel) || (!prev_busy && busy)}, 32'd1);
            end
            if (m_valid && m_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got beat %0h sel %0b expected none",
                             m_data, sel);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", {24'd0, m_data}, {24'd0, e.data});
                    chk("sb_last", {31'd0, m_last}, {31'd0, e.last});
                    chk("sb_sel", {31'd0, sel}, {31'd0, e.sel});
                end
            end
        end
        prev_rst  = rst;
        prev_busy = busy;
        prev_sel  = sel;
    end

    // One cycle of source BFM activity; g0/g1 gate each source's valid.
    task automatic step(input bit g0, input bit g1);
        @(negedge clk);
        s0_valid = g0 && (s0q.size() > 0);
        {s0_data, s0_last} = (s0q.size() > 0) ? s0q[0] : '0;
        s1_valid = g1 && (s1q.size() > 0);
        {s1_data, s1_last} = (s1q.size() > 0) ? s1q[0] : '0;
        #1;
        smp_busy = busy; smp_sel = sel; smp_mvalid = m_valid;
        smp_s0r = s0_ready; smp_s1r = s1_ready;
        if (s0_valid && s0_ready) void'(s0q.pop_front());
        if (s1_valid && s1_ready) void'(s1q.pop_front());
    endtask

    task automatic run_out(input string name, input int bound);
        int n = 0;
        while ((s0q.size() > 0 || s1q.size() > 0) && n < bound) begin
            step(1'b1, 1'b1);
            n++;
        end
        chk({name, "_drained"}, s0q.size() + s1q.size(), 0);
        step(1'b0, 1'b0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int busy_cnt;
        logic prev_b;

        // Reset values
        rst = 1'b1;
        m_ready = 1'b1;
        s0_valid = 1'b1; s0_last = 1'b1; s0_data = 8'h5A;
        s1_valid = 1'b1; s1_last = 1'b0; s1_data = 8'hC3;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
        chk("rst_s1_ready", {31'd0, s1_ready}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'h5A);
        chk("rst_m_last", {31'd0, m_last}, 32'd1);
        do_reset();

        // Tables: s0 three-beat packet, then s1 packet with an m_ready stall
        vecs.push_back(mk(1,0,8'h11, 0,0,8'h00, 1, 0,0,0,0,0, 8'h11,0));
        vecs.push_back(mk(1,0,8'h11, 0,0,8'h00, 1, 1,0,1,1,0, 8'h11,0));
        vecs.push_back(mk(1,0,8'h22, 0,0,8'h00, 1, 1,0,1,1,0, 8'h22,0));
        vecs.push_back(mk(1,1,8'h33, 0,0,8'h00, 1, 1,0,1,1,0, 8'h33,1));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 0,0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hA0, 1, 0,0,0,0,0, 8'h00,0));
        vecs.push_back(mk(0,0,8'h00, 1,0,8'hA0, 1, 1,1,1,0,1, 8'hA0,0));
        vecs.push_back(mk(0,0,8'h00, 1,1,8'hA1, 0, 1,1,1,0,0, 8'hA1,1));
        vecs.push_back(mk(0,0,8'h00, 1,1,8'hA1, 1, 1,1,1,0,1, 8'hA1,1));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 1, 0,1,0,0,0, 8'h00,0));
        exp_q.push_back(mke(8'h11, 1'b0, 1'b0));
        exp_q.push_back(mke(8'h22, 1'b0, 1'b0));
        exp_q.push_back(mke(8'h33, 1'b1, 1'b0));
        exp_q.push_back(mke(8'hA0, 1'b0, 1'b1));
        exp_q.push_back(mke(8'hA1, 1'b1, 1'b1));
        acc0 = accepts;
        foreach (vecs[i]) begin
            @(negedge clk);
            s0_valid = vecs[i].s0_valid; s0_last = vecs[i].s0_last; s0_data = vecs[i].s0_data;
            s1_valid = vecs[i].s1_valid; s1_last = vecs[i].s1_last; s1_data = vecs[i].s1_data;
            m_ready = vecs[i].m_ready;
            #1;
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].e_sel});
            chk($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].e_m_valid});
            chk($sformatf("vec%0d_s0_ready", i), {31'd0, s0_ready}, {31'd0, vecs[i].e_s0_ready});
            chk($sformatf("vec%0d_s1_ready", i), {31'd0, s1_ready}, {31'd0, vecs[i].e_s1_ready});
            chk($sformatf("vec%0d_m_data", i), {24'd0, m_data}, {24'd0, vecs[i].e_m_data});
            chk($sformatf("vec%0d_m_last", i), {31'd0, m_last}, {31'd0, vecs[i].e_m_last});
        end
        m_ready = 1'b1;
        step(1'b0, 1'b0);
        chk("table_accepts", accepts - acc0, 5);
        chk("table_sb_empty", exp_q.size(), 0);

        // Both sources request after reset: s0, s1, then s0 again
        do_reset();
        s0q.push_back(mkb(8'h01, 1'b0)); s0q.push_back(mkb(8'h02, 1'b1));
        s0q.push_back(mkb(8'h03, 1'b1));
        s1q.push_back(mkb(8'h81, 1'b0)); s1q.push_back(mkb(8'h82, 1'b1));
        exp_q.push_back(mke(8'h01, 1'b0, 1'b0)); exp_q.push_back(mke(8'h02, 1'b1, 1'b0));
        exp_q.push_back(mke(8'h81, 1'b0, 1'b1)); exp_q.push_back(mke(8'h82, 1'b1, 1'b1));
        exp_q.push_back(mke(8'h03, 1'b1, 1'b0));
        step(1'b1, 1'b1);
        chk("tie_req_busy", {31'd0, smp_busy}, 32'd0);
        step(1'b1, 1'b1);
        chk("tie_grant_busy", {31'd0, smp_busy}, 32'd1);
        chk("tie_grant_sel", {31'd0, smp_sel}, 32'd0);
        run_out("tie", 40);

        // s1 drops valid mid-packet while s0 waits
        s1q.push_back(mkb(8'hB0, 1'b0)); s1q.push_back(mkb(8'hB1, 1'b0));
        s1q.push_back(mkb(8'hB2, 1'b1));
        exp_q.push_back(mke(8'hB0, 1'b0, 1'b1)); exp_q.push_back(mke(8'hB1, 1'b0, 1'b1));
        exp_q.push_back(mke(8'hB2, 1'b1, 1'b1)); exp_q.push_back(mke(8'hC0, 1'b1, 1'b0));
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("drop_grant_sel", {31'd0, smp_sel}, 32'd1);
        s0q.push_back(mkb(8'hC0, 1'b1));
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0);
            chk($sformatf("drop%0d_busy", k), {31'd0, smp_busy}, 32'd1);
            chk($sformatf("drop%0d_sel", k), {31'd0, smp_sel}, 32'd1);
            chk($sformatf("drop%0d_m_valid", k), {31'd0, smp_mvalid}, 32'd0);
            chk($sformatf("drop%0d_s0_ready", k), {31'd0, smp_s0r}, 32'd0);
        end
        run_out("drop", 40);

        // Asynchronous reset in the middle of an s0 packet
        s0q.push_back(mkb(8'hD0, 1'b0)); s0q.push_back(mkb(8'hD1, 1'b0));
        s0q.push_back(mkb(8'hD2, 1'b1));
        exp_q.push_back(mke(8'hD0, 1'b0, 1'b0));
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        @(negedge clk);
        s0_valid = 1'b1; {s0_data, s0_last} = s0q[0];
        #1;
        chk("arst_pre_busy", {31'd0, busy}, 32'd1);
        chk("arst_pre_s0_ready", {31'd0, s0_ready}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_s0_ready", {31'd0, s0_ready}, 32'd0);
        chk("arst_s1_ready", {31'd0, s1_ready}, 32'd0);
        chk("arst_sel", {31'd0, sel}, 32'd0);
        @(negedge clk);
        #1;
        chk("arst_held_busy", {31'd0, busy}, 32'd0);
        chk("arst_held_s0_ready", {31'd0, s0_ready}, 32'd0);
        s0q.delete();
        s0_valid = 1'b0;
        rst = 1'b0;
        chk("arst_sb_empty", exp_q.size(), 0);
        s1q.push_back(mkb(8'hE0, 1'b1));
        exp_q.push_back(mke(8'hE0, 1'b1, 1'b1));
        step(1'b1, 1'b1);
        chk("arst_req_busy", {31'd0, smp_busy}, 32'd0);
        step(1'b1, 1'b1);
        chk("arst_grant_busy", {31'd0, smp_busy}, 32'd1);
        chk("arst_grant_sel", {31'd0, smp_sel}, 32'd1);
        run_out("arst", 10);

        // Single-beat packets on both sources: strict alternation with one bubble each
        for (int k = 0; k < 5; k++) begin
            s0q.push_back(mkb(8'h60 + 8'(k), 1'b1));
            s1q.push_back(mkb(8'h70 + 8'(k), 1'b1));
            exp_q.push_back(mke(8'h60 + 8'(k), 1'b1, 1'b0));
            exp_q.push_back(mke(8'h70 + 8'(k), 1'b1, 1'b1));
        end
        busy_cnt = 0;
        prev_b = 1'b0;
        for (int n = 0; n < 60 && (s0q.size() > 0 || s1q.size() > 0); n++) begin
            step(1'b1, 1'b1);
            chk("single_bubble", {31'd0, prev_b & smp_busy}, 32'd0);
            if (smp_busy) busy_cnt++;
            prev_b = smp_busy;
        end
        chk("single_busy_cycles", busy_cnt, 10);
        run_out("single", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_2x1_arbiter.md
Name: mux_2x1_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 2:1 output channel between two streaming requesters (s0, s1).
- Each requester uses valid/ready/last; a grant is locked for a whole packet (until the beat with last=1 is accepted).
- The block drives the select of a W-bit 2:1 bus mux that steers the granted source to the single master port.
- It sits between two producers and one shared consumer.

Parameters:
W, 8, data width of each source and the master port.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- s0_data  input  W  source 0 data
- s0_valid  input  1  source 0 beat valid
- s0_last  input  1  source 0 final beat of packet
- s0_ready  output  1  source 0 beat accepted when valid&ready
- s1_data  input  W  source 1 data
- s1_valid  input  1  source 1 beat valid
- s1_last  input  1  source 1 final beat of packet
- s1_ready  output  1  source 1 beat accepted when valid&ready
- m_data  output  W  muxed data
- m_valid  output  1  muxed valid
- m_last  output  1  muxed last
- m_ready  input  1  consumer ready
- sel  output  1  registered mux select (0=s0, 1=s1)
- busy  output  1  1 while a grant is locked

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous, active-high (rst); state is reset immediately on rst assertion.
- Reset values:
  - state=IDLE, sel=0, last_served=1 (s0 wins first arbitration), busy=0.
  - s0_ready=0, s1_ready=0, m_valid=0.
  - m_data and m_last follow the mux, i.e. s0_data/s0_last.
- States:
  - IDLE: no grant. All ready outputs=0, m_valid=0.
    - If exactly one sX_valid=1: next sel=X, go to BUSY.
    - If both valid: next sel = !last_served, go to BUSY.
    - If none valid: stay in IDLE.
  - BUSY: grant locked to sel.
    - m_data/m_last = granted source's data/last through the mux (combinational).
    - m_valid = granted sX_valid.
    - granted sX_ready = m_ready; non-granted ready = 0.
    - On an accepted beat (m_valid & m_ready) with m_last=1: last_served <= sel, go to IDLE.
    - An accepted beat with last=0 stays in BUSY.
- Latency:
  - A request seen in IDLE at cycle N gives grant (sel, busy=1) at N+1; the first transfer is possible at N+1.
  - After a last-beat accept there is exactly one IDLE bubble cycle before the next grant becomes effective.
  - Peak throughput is one beat per cycle within a packet.
- Boundaries:
  - Granted source drops valid mid-packet: the grant stays locked (no timeout). m_valid follows and goes 0.
  - Non-granted source asserts valid: it is ignored and its ready is held 0 until its own grant.
  - m_ready=0 while m_valid=1: hold state. Data stability is the source's obligation.
  - Single-beat packet (valid & last on the first BUSY cycle, m_ready=1): the grant lasts exactly one cycle.
  - Same source requests back-to-back with the other idle: it is re-granted after the bubble.
  - Both sources continuously requesting: grants strictly alternate s0, s1, s0, ...
  - rst asserted mid-packet: immediate return to reset values. The partial packet is abandoned; no beat is accepted while rst=1.
- Invariants (assert in the bench):
  - s0_ready & s1_ready is never 1.
  - ready is 0 in IDLE.
  - sel changes only on the IDLE -> BUSY transition.

Decomposition:
- Shared package mux_arb_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1;
  - source index constants SRC0=1'b0, SRC1=1'b1.
- Sub-module mux_2x1_bus (parameter W): vector 2:1 mux f = s ? x2 : x1.
  - Instantiated once with width W+2 to carry {data, last, valid}.

Test Plan:
1. After rst, s0 sends 3 beats (0x11, 0x22, 0x33 with last) with m_ready=1 -> grant at cycle+1, m_data 11, 22, 33 on consecutive cycles, then busy=0 for one cycle.
2. s0 and s1 both valid from IDLE after reset -> s0 granted first (sel=0). After s0's last beat, s1 is granted (sel=1); s0 re-requesting is served after s1.
3. s1 packet 0xA0, 0xA1(last) with m_ready toggling 1,0,1 -> m_data holds 0xA1 through the stall. Exactly 2 beats are accepted; s0_ready stays 0 throughout.
4. s1 granted, mid-packet s1_valid drops for 2 cycles while s0_valid=1 -> grant stays on s1, m_valid=0 for 2 cycles, s0 not served until s1's last is accepted.
5. Assert rst asynchronously (between clock edges) mid s0 packet -> busy, m_valid and ready drop immediately. After release, a fresh s1-only request is granted with sel=1.
6. Single-beat packets continuously on both sources for 10 packets -> sel sequence 0,1,0,1,..., one bubble cycle between packets, never both readys high.
